// File: rtl/fighter_pkg.sv
// Shared types and constants for the projectile arbiter: FSM state encoding,
// shot-owner codes, default playfield bounds and two small helpers.
package fighter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LAUNCH   = 2'd1,
    ST_FLIGHT   = 2'd2,
    ST_COOLDOWN = 2'd3
  } arb_state_e;

  localparam logic OWNER_PLAYER = 1'b0;
  localparam logic OWNER_NPC    = 1'b1;

  localparam logic [9:0] DEFAULT_X_MIN = 10'd0;
  localparam logic [9:0] DEFAULT_X_MAX = 10'd639;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic out_of_bounds(input logic [9:0] x,
                                         input logic [9:0] lo,
                                         input logic [9:0] hi);
    return (x < lo) || (x > hi);
  endfunction

endpackage

// File: rtl/projectile_arbiter_if.sv
// Bundle between the stage controller / projectile engine side (master) and
// the projectile arbiter (slave).
interface projectile_arbiter_if;
  logic       frame_clk;
  logic       battle_en;
  logic       player_req;
  logic       npc_req;
  logic       proj_contact;
  logic [9:0] proj_x;
  logic       proj_activate;
  logic       proj_owner;
  logic       busy;
  logic       player_hit;
  logic       npc_hit;
  logic [3:0] player_score;
  logic [3:0] npc_score;

  modport master (
    output frame_clk, battle_en, player_req, npc_req, proj_contact, proj_x,
    input  proj_activate, proj_owner, busy, player_hit, npc_hit,
           player_score, npc_score
  );

  modport slave (
    input  frame_clk, battle_en, player_req, npc_req, proj_contact, proj_x,
    output proj_activate, proj_owner, busy, player_hit, npc_hit,
           player_score, npc_score
  );
endinterface

// File: rtl/frame_tick_gen.sv
// Rising-edge detector on the VGA vertical sync: one-cycle tick on the first
// Clk where frame_clk is sampled high after having been sampled low.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk_i,
  output logic tick_o
);

  logic frame_clk_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (!Reset_n) frame_clk_q <= 1'b0;
    else          frame_clk_q <= frame_clk_i;
  end

  assign tick_o = frame_clk_i & ~frame_clk_q;

endmodule

// File: rtl/projectile_arbiter.sv
// Arbitrates the single shared projectile between player and NPC, tracks the
// flight outcome (hit / miss / timeout), cooldown, and per-side hit counts.
module projectile_arbiter
  import fighter_pkg::*;
#(
  parameter int unsigned COOLDOWN_FRAMES   = 8,
  parameter int unsigned MAX_FLIGHT_FRAMES = 160,
  parameter logic [9:0]  X_MIN             = DEFAULT_X_MIN,
  parameter logic [9:0]  X_MAX             = DEFAULT_X_MAX
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  projectile_arbiter_if.slave  bus
);

  localparam logic [7:0] COOLDOWN_LAST = 8'(COOLDOWN_FRAMES - 1);
  localparam logic [7:0] FLIGHT_LAST   = 8'(MAX_FLIGHT_FRAMES - 1);

  arb_state_e state_q;
  logic [7:0] frame_cnt_q;
  logic       last_owner_q;
  logic       owner_q;
  logic       proj_activate_q;
  logic       player_hit_q;
  logic       npc_hit_q;
  logic [3:0] player_score_q;
  logic [3:0] npc_score_q;

  logic       frame_tick;
  logic       grant_valid_d;
  logic       grant_owner_d;

  frame_tick_gen u_frame_tick_gen (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_clk_i (bus.frame_clk),
    .tick_o      (frame_tick)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_valid_d = bus.player_req | bus.npc_req;
    grant_owner_d = OWNER_PLAYER;
    if (bus.player_req && bus.npc_req) grant_owner_d = ~last_owner_q;
    else if (bus.npc_req)              grant_owner_d = OWNER_NPC;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q         <= ST_IDLE;
      frame_cnt_q     <= '0;
      last_owner_q    <= OWNER_NPC;
      owner_q         <= OWNER_PLAYER;
      proj_activate_q <= 1'b0;
      player_hit_q    <= 1'b0;
      npc_hit_q       <= 1'b0;
      player_score_q  <= '0;
      npc_score_q     <= '0;
    end else begin
      proj_activate_q <= 1'b0;
      player_hit_q    <= 1'b0;
      npc_hit_q       <= 1'b0;
      if (!bus.battle_en) begin
        state_q     <= ST_IDLE;
        frame_cnt_q <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (grant_valid_d) begin
              state_q         <= ST_LAUNCH;
              owner_q         <= grant_owner_d;
              last_owner_q    <= grant_owner_d;
              proj_activate_q <= 1'b1;
            end
          end
          ST_LAUNCH: begin
            state_q     <= ST_FLIGHT;
            frame_cnt_q <= '0;
          end
          ST_FLIGHT: begin
            // Each score counts hits taken by that side: a player shot that
            // connects raises npc_hit and npc_score, and vice versa.
            if (bus.proj_contact) begin
              state_q     <= ST_COOLDOWN;
              frame_cnt_q <= '0;
              if (owner_q == OWNER_PLAYER) begin
                npc_hit_q   <= 1'b1;
                npc_score_q <= sat_inc(npc_score_q);
              end else begin
                player_hit_q   <= 1'b1;
                player_score_q <= sat_inc(player_score_q);
              end
            end else if (out_of_bounds(bus.proj_x, X_MIN, X_MAX) ||
                         (frame_tick && frame_cnt_q == FLIGHT_LAST)) begin
              state_q     <= ST_COOLDOWN;
              frame_cnt_q <= '0;
            end else if (frame_tick) begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end
          end
          ST_COOLDOWN: begin
            if (frame_tick) begin
              if (frame_cnt_q == COOLDOWN_LAST) begin
                state_q     <= ST_IDLE;
                frame_cnt_q <= '0;
              end else begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
              end
            end
          end
          default: begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.proj_activate = proj_activate_q;
  assign bus.proj_owner    = owner_q;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.player_hit    = player_hit_q;
  assign bus.npc_hit       = npc_hit_q;
  assign bus.player_score  = player_score_q;
  assign bus.npc_score     = npc_score_q;

endmodule

// File: tb/tb_projectile_arbiter.sv
// Directed bench for projectile_arbiter (MAX_FLIGHT_FRAMES=4, COOLDOWN_FRAMES=8);
// inputs change and outputs are checked 1 ns after each rising Clk.
module tb_projectile_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  projectile_arbiter_if bus ();

  projectile_arbiter #(
    .COOLDOWN_FRAMES   (8),
    .MAX_FLIGHT_FRAMES (4)
  ) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Each frame: one low sample then one high sample, so the tick lands on
  // the last edge of the frame.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_clk = 1'b0;
      cyc();
      bus.frame_clk = 1'b1;
      cyc();
    end
    bus.frame_clk = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n            = 1'b0;
    bus.frame_clk    = 1'b0;
    bus.battle_en    = 1'b0;
    bus.player_req   = 1'b0;
    bus.npc_req      = 1'b0;
    bus.proj_contact = 1'b0;
    bus.proj_x       = 10'd320;
    cyc();
    cyc();

    // Reset state
    check("rst_busy",     32'(bus.busy),          32'd0);
    check("rst_activate", 32'(bus.proj_activate), 32'd0);
    check("rst_owner",    32'(bus.proj_owner),    32'd0);
    check("rst_phit",     32'(bus.player_hit),    32'd0);
    check("rst_nhit",     32'(bus.npc_hit),       32'd0);
    check("rst_pscore",   32'(bus.player_score),  32'd0);
    check("rst_nscore",   32'(bus.npc_score),     32'd0);
    rst_n = 1'b1;
    cyc();

    // Single player request: launch one cycle after the IDLE sample
    bus.battle_en  = 1'b1;
    bus.player_req = 1'b1;
    cyc();
    check("t1_activate", 32'(bus.proj_activate), 32'd1);
    check("t1_owner",    32'(bus.proj_owner),    32'd0);
    check("t1_busy",     32'(bus.busy),          32'd1);
    bus.player_req = 1'b0;
    cyc();
    check("t1_activate_1cyc", 32'(bus.proj_activate), 32'd0);
    bus.proj_x = 10'd700;
    cyc();
    check("t1_miss_nhit", 32'(bus.npc_hit), 32'd0);
    bus.proj_x = 10'd320;
    frames(7);
    check("t1_cool_busy7", 32'(bus.busy), 32'd1);
    frames(1);
    check("t1_cool_idle8", 32'(bus.busy), 32'd0);

    // Fresh reset, both requesting: owners alternate player, NPC, player
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    bus.player_req = 1'b1;
    bus.npc_req    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("t2_activate", 32'(bus.proj_activate), 32'd1);
      check("t2_owner",    32'(bus.proj_owner),    32'(k % 2));
      cyc();
      bus.proj_x = 10'd700;
      cyc();
      check("t2_phit", 32'(bus.player_hit), 32'd0);
      check("t2_nhit", 32'(bus.npc_hit),    32'd0);
      bus.proj_x = 10'd320;
      frames(8);
      check("t2_idle", 32'(bus.busy), 32'd0);
      if (k == 2) begin
        bus.player_req = 1'b0;
        bus.npc_req    = 1'b0;
      end
    end
    check("t2_nscore", 32'(bus.npc_score), 32'd0);

    // Player shot: contact ignored in LAUNCH, wins over out-of-bounds in FLIGHT
    bus.player_req = 1'b1;
    cyc();
    check("t3_owner", 32'(bus.proj_owner), 32'd0);
    bus.player_req   = 1'b0;
    bus.proj_contact = 1'b1;
    cyc();
    check("t3_launch_nohit", 32'(bus.npc_hit), 32'd0);
    bus.proj_x = 10'd700;
    cyc();
    check("t3_nhit",   32'(bus.npc_hit),      32'd1);
    check("t3_phit",   32'(bus.player_hit),   32'd0);
    check("t3_nscore", 32'(bus.npc_score),    32'd1);
    check("t3_pscore", 32'(bus.player_score), 32'd0);
    bus.proj_contact = 1'b0;
    bus.proj_x       = 10'd320;
    cyc();
    check("t3_nhit_1cyc", 32'(bus.npc_hit), 32'd0);
    frames(8);
    check("t3_idle", 32'(bus.busy), 32'd0);

    // NPC shot times out on the 4th frame tick (x=639 is still in bounds)
    bus.npc_req = 1'b1;
    cyc();
    check("t4_owner", 32'(bus.proj_owner), 32'd1);
    bus.npc_req = 1'b0;
    bus.proj_x  = 10'd639;
    cyc();
    frames(4);
    check("t4_timeout_phit", 32'(bus.player_hit), 32'd0);
    frames(7);
    check("t4_busy_11", 32'(bus.busy), 32'd1);
    frames(1);
    check("t4_idle_12", 32'(bus.busy), 32'd0);
    bus.proj_x = 10'd320;

    // battle_en dropped in FLIGHT together with contact
    bus.player_req = 1'b1;
    cyc();
    bus.player_req = 1'b0;
    cyc();
    bus.battle_en    = 1'b0;
    bus.proj_contact = 1'b1;
    cyc();
    check("t5_idle",   32'(bus.busy),      32'd0);
    check("t5_nhit",   32'(bus.npc_hit),   32'd0);
    check("t5_nscore", 32'(bus.npc_score), 32'd1);
    bus.proj_contact = 1'b0;
    bus.battle_en    = 1'b1;
    cyc();
    check("t5_stay_idle", 32'(bus.busy), 32'd0);

    // 16 NPC hits: player_score saturates, pulse still issued
    for (int i = 0; i < 16; i++) begin
      bus.npc_req = 1'b1;
      cyc();
      bus.npc_req = 1'b0;
      cyc();
      bus.proj_contact = 1'b1;
      cyc();
      check("t6_phit",   32'(bus.player_hit),   32'd1);
      check("t6_pscore", 32'(bus.player_score), (i < 15) ? 32'(i + 1) : 32'd15);
      bus.proj_contact = 1'b0;
      bus.battle_en    = 1'b0;
      cyc();
      bus.battle_en = 1'b1;
    end
    check("t6_nscore_kept", 32'(bus.npc_score), 32'd1);

    // Reset mid-FLIGHT with contact: abort, no pulse, scores cleared
    bus.player_req = 1'b1;
    cyc();
    bus.player_req = 1'b0;
    cyc();
    rst_n            = 1'b0;
    bus.proj_contact = 1'b1;
    cyc();
    check("t7_busy",   32'(bus.busy),         32'd0);
    check("t7_nhit",   32'(bus.npc_hit),      32'd0);
    check("t7_pscore", 32'(bus.player_score), 32'd0);
    check("t7_nscore", 32'(bus.npc_score),    32'd0);
    bus.proj_contact = 1'b0;
    rst_n            = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
